// File: rtl/ahb_slave_port_mux_pkg.sv
// Shared AHB encodings and grant-vector helpers for the per-slave port multiplexer.
package ahb_slave_port_mux_pkg;

  typedef enum logic [2:0] {
    BurstSingle = 3'd0,
    BurstIncr   = 3'd1,
    BurstWrap4  = 3'd2,
    BurstIncr4  = 3'd3,
    BurstWrap8  = 3'd4,
    BurstIncr8  = 3'd5,
    BurstWrap16 = 3'd6,
    BurstIncr16 = 3'd7
  } hburst_type;

  localparam int unsigned HburstW = $bits(hburst_type);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransBusy   = 2'b01;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;

  localparam logic RespOkay  = 1'b0;
  localparam logic RespError = 1'b1;

  typedef enum logic [0:0] {
    StNormal = 1'b0,
    StErr2   = 1'b1
  } err_state_e;

  // Callers zero-extend narrower grant vectors to 32 bits.
  function automatic logic is_onehot(input logic [31:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic logic is_multihot(input logic [31:0] v);
    return $countones(v) > 1;
  endfunction

endpackage

// File: rtl/ahb_onehot_mux.sv
// One-hot select multiplexer; an all-zero or multi-hot select yields all zeros.
module ahb_onehot_mux
  import ahb_slave_port_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 2
) (
  input  logic [N-1:0]            sel_i,
  input  logic [N-1:0][WIDTH-1:0] data_i,
  output logic [WIDTH-1:0]        data_o
);

  logic sel_valid;

  assign sel_valid = is_onehot(32'(sel_i));

  always_comb begin
    data_o = '0;
    if (sel_valid) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (sel_i[i]) begin
          data_o = data_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/ahb_slave_port_mux.sv
// Per-slave master-to-slave mux: steers the granted master's address phase, tracks the
// data-phase owner for hwdata/hresp routing, and polices the two-cycle ERROR response.
module ahb_slave_port_mux
  import ahb_slave_port_mux_pkg::*;
#(
  parameter int unsigned MASTER_NUM = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                                hclk,
  input  logic                                hreset,
  input  logic [MASTER_NUM-1:0]               hgrant,
  input  logic [MASTER_NUM-1:0][ADDR_W-1:0]   m_haddr,
  input  logic [MASTER_NUM-1:0][1:0]          m_htrans,
  input  logic [MASTER_NUM-1:0]               m_hwrite,
  input  logic [MASTER_NUM-1:0][2:0]          m_hsize,
  input  logic [MASTER_NUM-1:0][HburstW-1:0]  m_hburst,
  input  logic [MASTER_NUM-1:0][DATA_W-1:0]   m_hwdata,
  output logic [ADDR_W-1:0]                   s_haddr,
  output logic [1:0]                          s_htrans,
  output logic                                s_hwrite,
  output logic [2:0]                          s_hsize,
  output logic [HburstW-1:0]                  s_hburst,
  output logic [DATA_W-1:0]                   s_hwdata,
  input  logic [DATA_W-1:0]                   s_hrdata,
  input  logic                                s_hready,
  input  logic                                s_hresp,
  output logic [DATA_W-1:0]                   m_hrdata,
  output logic [MASTER_NUM-1:0]               m_hready,
  output logic [MASTER_NUM-1:0]               m_hresp,
  output logic                                hwait,
  output logic                                grant_err,
  output logic                                prot_err
);

  localparam int unsigned BundleW = ADDR_W + 2 + 1 + 3 + HburstW;

  logic [MASTER_NUM-1:0][BundleW-1:0] m_bundle;
  logic [BundleW-1:0]                 s_bundle;
  logic [1:0]                         sel_htrans;
  logic                               sel_active;
  logic [MASTER_NUM-1:0]              dph_owner_d, dph_owner_q;
  err_state_e                         err_state_q;
  logic                               grant_err_q, prot_err_q;

  always_comb begin
    for (int unsigned i = 0; i < MASTER_NUM; i++) begin
      m_bundle[i] = {m_haddr[i], m_htrans[i], m_hwrite[i], m_hsize[i], m_hburst[i]};
    end
  end

  ahb_onehot_mux #(
    .WIDTH (BundleW),
    .N     (MASTER_NUM)
  ) u_addr_mux (
    .sel_i  (hgrant),
    .data_i (m_bundle),
    .data_o (s_bundle)
  );

  ahb_onehot_mux #(
    .WIDTH (DATA_W),
    .N     (MASTER_NUM)
  ) u_wdata_mux (
    .sel_i  (dph_owner_q),
    .data_i (m_hwdata),
    .data_o (s_hwdata)
  );

  assign {s_haddr, sel_htrans, s_hwrite, s_hsize, s_hburst} = s_bundle;

  // ERR2 cancels the pipelined transfer at the slave only; ownership still follows the master.
  assign s_htrans   = (err_state_q == StErr2) ? TransIdle : sel_htrans;
  assign sel_active = (sel_htrans == TransNonseq) || (sel_htrans == TransSeq);

  always_comb begin
    dph_owner_d = dph_owner_q;
    if (s_hready) begin
      dph_owner_d = (is_onehot(32'(hgrant)) && sel_active) ? hgrant : '0;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dph_owner_q <= '0;
      err_state_q <= StNormal;
      grant_err_q <= 1'b0;
      prot_err_q  <= 1'b0;
    end else begin
      dph_owner_q <= dph_owner_d;
      if (is_multihot(32'(hgrant))) begin
        grant_err_q <= 1'b1;
      end
      case (err_state_q)
        StNormal: begin
          if (s_hresp == RespError) begin
            if (s_hready) begin
              prot_err_q <= 1'b1;
            end else begin
              err_state_q <= StErr2;
            end
          end
        end
        StErr2: begin
          err_state_q <= StNormal;
          if (!((s_hresp == RespError) && s_hready)) begin
            prot_err_q <= 1'b1;
          end
        end
        default: err_state_q <= StNormal;
      endcase
    end
  end

  assign m_hrdata  = s_hrdata;
  assign m_hready  = {MASTER_NUM{s_hready}};
  assign m_hresp   = dph_owner_q & {MASTER_NUM{s_hresp}};
  assign hwait     = ~s_hready;
  assign grant_err = grant_err_q;
  assign prot_err  = prot_err_q;

endmodule
